nibble_serial_adder: RTL
========================

# nibble_serial_adder

Multi-cycle wide adder that feeds a single 4-bit carry-lookahead adder slice one nibble per clock. It latches two `4*NIBBLES`-bit operands and a carry-in on a start request. It then steps the slice from least- to most-significant nibble, holding the inter-nibble carry in a register, and presents the full sum and carry-out with a one-cycle done pulse. It is the area-lean alternative to a cascaded CLA for datapaths that can tolerate `NIBBLES+1` cycles of latency.

## Interface
- `NIBBLES`, default 4: number of 4-bit nibbles. Operand width W = 4*NIBBLES. Legal range 1..16.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new addition. Sampled only while `ready`=1.
- `a`, input, W: operand A. Sampled on the accepted `start` edge.
- `b`, input, W: operand B. Sampled on the accepted `start` edge.
- `cin`, input, 1: carry into nibble 0. Sampled on the accepted `start` edge.
- `ready`, output, 1: block is idle and will accept `start`.
- `done`, output, 1: one-cycle pulse; `sum`/`cout` are valid for a new result.
- `sum`, output, W: registered result, held until the next completion.
- `cout`, output, 1: registered carry out of the top nibble.

## Operation
- **Datapath:**
  - One 4-bit CLA slice (A, B, Cin -> Sum, Cout) is driven by nibble `idx` of the latched operands and by carry register `c_reg`.
  - Partial-sum register `acc` (W bits): the slice Sum is written into nibble `idx`.
  - Index counter `idx` has width ceil(log2(NIBBLES)), minimum 1 bit.
- **FSM (3 states):**
  - IDLE:
    - `ready`=1.
    - On `start`=1: latch `a`, `b` into `a_reg`, `b_reg`; set `c_reg`<=`cin`, `idx`<=0, `acc`<=0; go to RUN.
  - RUN:
    - Each cycle: `acc[idx]`<=slice Sum, `c_reg`<=slice Cout.
    - If `idx`==NIBBLES-1: `sum`<=`acc` with the top nibble replaced by the current slice Sum; `cout`<=slice Cout; go to DONE.
    - Otherwise `idx`<=`idx`+1.
  - DONE:
    - `done`=1 for exactly this cycle; go to IDLE unconditionally.
- **Input handling:**
  - `start` is ignored in RUN and DONE; there is no queueing.
  - Operand changes after acceptance have no effect.
- **Output registers:**
  - `sum` and `cout` change only on the RUN->DONE transition.
  - Partial results are never visible on `sum`.
  - Outputs hold their value through IDLE and through the next operation until that operation completes.
- **Arithmetic:**
  - The result is unsigned: {`cout`,`sum`} = `a` + `b` + `cin`, exact in W+1 bits.
  - Carry wraps out of the top nibble into `cout` only; no overflow flag.
- **Reset** (synchronous, any state, including mid-RUN):
  - State returns to IDLE and the operation is aborted.
  - `sum`=0, `cout`=0, `done`=0, `ready`=1.
  - `idx`, `c_reg`, `acc` and the operand registers are cleared.
  - `start` asserted in the same cycle as `rst` is ignored.
- `ready` and `done` are decoded from the state register (glitch-free, no combinational path from inputs).

## Timing
- **Latency:**
  - `start` accepted at edge E0.
  - Nibble k is processed at edge E(k+1).
  - `sum`/`cout` update at edge E(NIBBLES).
  - `done` is high for the cycle between E(NIBBLES) and E(NIBBLES+1).
- **Handshake:**
  - `ready` deasserts the cycle after E0.
  - `ready` reasserts after E(NIBBLES+1).
  - A new `start` is accepted no earlier than E(NIBBLES+1).
- **Throughput:** one addition per NIBBLES+2 cycles with back-to-back `start`.
- **NIBBLES=1:** RUN lasts one cycle; `done` is high after E1.
- **Critical path:** one 4-bit CLA slice plus register setup, independent of NIBBLES.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles.
  - Required: `ready`=1, `done`=0, `sum`=0x0000, `cout`=0.
- **Basic add (NIBBLES=4):**
  - Stimulus: `a`=0x1234, `b`=0x4321, `cin`=0, `start` pulse at E0.
  - Required: `done` high only between E4 and E5; `sum`=0x5555, `cout`=0.
  - Required: `sum` stays 0x0000 before E4.
- **Full carry ripple:**
  - Stimulus: 0xFFFF+0x0001 with `cin`=0, then 0xFFFF+0x0000 with `cin`=1.
  - Required: both give `sum`=0x0000, `cout`=1.
  - Stimulus: 0x8000+0x8000.
  - Required: `sum`=0x0000, `cout`=1.
- **Busy ignore and back-to-back:**
  - Stimulus: start 0x0F0F+0x00F1, then hold `start`=1 continuously with `a`=0x0001, `b`=0x0001 applied after E0.
  - Required: first result 0x1000 with `cout`=0.
  - Required: the second operation is accepted at E6, and `done` pulses again after E10 with `sum`=0x0002.
- **Reset mid-operation:**
  - Stimulus: start 0xAAAA+0x5555 with `cin`=1; assert `rst` at E2.
  - Required: no `done` pulse; `sum`=0, `cout`=0, `ready`=1 the cycle after reset.
  - Stimulus: next operation 0x0003+0x0004.
  - Required: `sum`=0x0007.
- **Parameter sweep:**
  - Stimulus: NIBBLES=1 and NIBBLES=8, 1000 random operand sets each.
  - Required: {`cout`,`sum`} matches `a`+`b`+`cin`.
  - Required: `done` latency is exactly NIBBLES+1 cycles after the accepting edge.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one 4-bit carry-lookahead slice is stepped LSB->MSB
// one nibble per clock, with the inter-nibble carry held in a register.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
  input  logic                   i_cin,
  output logic                   o_ready,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_sum,
  output logic                   o_cout
);

  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [NIBBLES-1:0][3:0]   r_a;
  logic [NIBBLES-1:0][3:0]   r_b;
  logic [NIBBLES-1:0][3:0]   r_acc;
  logic [IDXW-1:0]           r_idx;
  logic                      r_c;

  logic [3:0]                w_a_nib;
  logic [3:0]                w_b_nib;
  logic [3:0]                w_g;
  logic [3:0]                w_p;
  logic [4:0]                w_c;
  logic [3:0]                w_sum_nib;
  logic [NIBBLES-1:0][3:0]   w_acc_next;

  // 4-bit carry-lookahead slice on the current nibble
  always_comb begin
    w_a_nib   = r_a[r_idx];
    w_b_nib   = r_b[r_idx];
    w_g       = w_a_nib & w_b_nib;
    w_p       = w_a_nib ^ w_b_nib;
    w_c[0]    = r_c;
    w_c[1]    = w_g[0] | (w_p[0] & r_c);
    w_c[2]    = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
    w_c[3]    = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & r_c);
    w_c[4]    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);
    w_sum_nib = w_p ^ w_c[3:0];
    w_acc_next        = r_acc;
    w_acc_next[r_idx] = w_sum_nib;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_c     <= 1'b0;
      o_ready <= 1'b1;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_c     <= i_cin;
            r_idx   <= '0;
            r_acc   <= '0;
            o_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_c   <= w_c[4];
          if (r_idx == LAST_IDX) begin
            o_sum   <= w_acc_next;
            o_cout  <= w_c[4];
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          o_done  <= 1'b0;
          o_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
